reg_file_cc: RTL and testbench

Eight-entry 16-bit general-purpose register file with condition-code (NZP) and branch-enable (BEN) registers, sitting directly upstream of the ALU in the LC-3 datapath. It decodes register fields from IR and drives SR1OUT, SR2OUT, the sign-extended imm5 (IMME) and the SR2 mux select to the ALU. It captures write-back data and condition codes from the shared BUS on the rising clock edge under control-FSM load strobes.

---
 rtl/reg_file_cc.sv | 114 +++++++++++
 tb/tb_reg_file_cc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_cc.sv
// reg_file_cc: eight 16-bit general-purpose registers, NZP condition codes and
// the branch-enable flag for an LC-3 style datapath.
//
// Register fields are decoded from IR. SR1OUT, SR2OUT, IMME and SR2MUX_SEL are
// combinational. Write-back data and condition codes come from BUS on the
// rising edge of Clk.
//
// Optional build macro REG_BYPASS_EN:
//   - Defined: a read port whose address matches DR while LD_REG=1 returns
//     BUS in the same cycle (write-through).
//   - Undefined: reads always return registered contents.
//
// Control: LD_REG, LD_CC and LD_BEN are plain single-cycle load strobes from
// the control FSM. There is no valid/ready handshake. A strobe that is high at
// a rising edge takes effect at that edge. When a strobe is low, its state holds.
module reg_file_cc #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] BUS,
  input  logic [WIDTH-1:0] IR,
  input  logic             LD_REG,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  output logic [WIDTH-1:0] SR1OUT,
  output logic [WIDTH-1:0] SR2OUT,
  output logic [WIDTH-1:0] IMME,
  output logic             SR2MUX_SEL,
  output logic             N,
  output logic             Z,
  output logic             P,
  output logic             BEN
);

  logic [WIDTH-1:0] regs [8];
  logic [2:0]       dr;
  logic [2:0]       sr1;
  logic [2:0]       sr2;
  logic             n_new;
  logic             z_new;
  logic             p_new;
  logic             ben_new;

  // Decode register addresses from IR and the two address muxes.
  always_comb begin
    dr  = DRMUX  ? 3'b111    : IR[11:9];
    sr1 = SR1MUX ? IR[8:6]   : IR[11:9];
    sr2 = IR[2:0];
  end

  // Next condition codes from BUS. Exactly one of N, Z and P is set.
  always_comb begin
    n_new = BUS[WIDTH-1];
    z_new = (BUS == '0);
    p_new = ~n_new & ~z_new;
  end

  // Branch enable is computed from the NZP held before the edge, so a
  // simultaneous CC load is not yet visible to it.
  always_comb begin
    ben_new = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
  end

  // Register storage. Only the destination register changes on a write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (LD_REG) begin
      regs[dr] <= BUS;
    end
  end

  // Condition-code flops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      N <= 1'b0;
      Z <= 1'b0;
      P <= 1'b0;
    end else if (LD_CC) begin
      N <= n_new;
      Z <= z_new;
      P <= p_new;
    end
  end

  // Branch-enable flop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      BEN <= 1'b0;
    end else if (LD_BEN) begin
      BEN <= ben_new;
    end
  end

  // Read ports, with optional same-cycle write-through from BUS.
  always_comb begin
    SR1OUT = regs[sr1];
    SR2OUT = regs[sr2];
`ifdef REG_BYPASS_EN
    if (LD_REG && (sr1 == dr)) SR1OUT = BUS;
    if (LD_REG && (sr2 == dr)) SR2OUT = BUS;
`endif
  end

  // Immediate sign extension and the ALU operand-B select.
  always_comb begin
    IMME       = {{(WIDTH-5){IR[4]}}, IR[4:0]};
    SR2MUX_SEL = IR[5];
  end

endmodule

// File: tb/tb_reg_file_cc.sv
// Directed testbench for reg_file_cc. Expected values are hand-computed constants.
module tb_reg_file_cc;

  localparam int W = 16;

  logic         Clk;
  logic         Reset;
  logic [W-1:0] BUS;
  logic [W-1:0] IR;
  logic         LD_REG;
  logic         LD_CC;
  logic         LD_BEN;
  logic         DRMUX;
  logic         SR1MUX;
  logic [W-1:0] SR1OUT;
  logic [W-1:0] SR2OUT;
  logic [W-1:0] IMME;
  logic         SR2MUX_SEL;
  logic         N;
  logic         Z;
  logic         P;
  logic         BEN;

  int errors = 0;
  int checks = 0;

  reg_file_cc #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .BUS(BUS), .IR(IR),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .SR1OUT(SR1OUT), .SR2OUT(SR2OUT), .IMME(IMME), .SR2MUX_SEL(SR2MUX_SEL),
    .N(N), .Z(Z), .P(P), .BEN(BEN)
  );

  // Clock generation.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 2 time units past it.
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  function automatic logic [W-1:0] mk_ir(input logic [2:0] f119, input logic [2:0] f86,
                                         input logic [2:0] f20);
    mk_ir = {4'b0001, f119, f86, 3'b000, f20};
  endfunction

  task automatic idle();
    LD_REG = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0; DRMUX = 1'b0; SR1MUX = 1'b0;
  endtask

  // Write a register using DR = IR[11:9].
  task automatic write_reg(input logic [2:0] r, input logic [W-1:0] v);
    idle();
    IR = mk_ir(r, 3'd0, 3'd0); BUS = v; LD_REG = 1'b1;
    step();
    idle();
  endtask

  task automatic load_cc(input logic [W-1:0] v);
    idle();
    BUS = v; LD_CC = 1'b1;
    step();
    idle();
  endtask

  logic [W-1:0] exp_v;

  initial begin
    idle();
    BUS = '0; IR = '0; Reset = 1'b1;
    #1;
    check("reset_sr1", SR1OUT, 16'h0000);
    check("reset_nzp", {13'b0, N, Z, P}, 16'h0000);
    step();
    Reset = 1'b0;

    // Load R3, set N, set BEN, then reset mid-cycle without a clock edge.
    write_reg(3'd3, 16'h1234);
    IR = mk_ir(3'd3, 3'd0, 3'd3); #1;
    check("pre_rst_r3_sr1", SR1OUT, 16'h1234);
    check("pre_rst_r3_sr2", SR2OUT, 16'h1234);
    load_cc(16'h8000);
    IR = 16'h0800; LD_BEN = 1'b1;
    step();
    idle();
    check("pre_rst_ben", {15'b0, BEN}, 16'h0001);
    #1 Reset = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      SR1MUX = 1'b1; IR = mk_ir(3'd0, 3'(k), 3'(k)); #1;
      check($sformatf("rst_sr1_r%0d", k), SR1OUT, 16'h0000);
      check($sformatf("rst_sr2_r%0d", k), SR2OUT, 16'h0000);
    end
    check("rst_nzp", {13'b0, N, Z, P}, 16'h0000);
    check("rst_ben", {15'b0, BEN}, 16'h0000);

    // Loads are ignored while Reset is high.
    idle();
    IR = mk_ir(3'd4, 3'd0, 3'd4); BUS = 16'hFFFF; LD_REG = 1'b1; LD_CC = 1'b1;
    step();
    check("rst_hold_r4", SR2OUT, 16'h0000);
    check("rst_hold_nzp", {13'b0, N, Z, P}, 16'h0000);
    idle();
    @(negedge Clk);
    Reset = 1'b0;
    step();

    // Write and read back all registers.
    for (int k = 0; k < 8; k++) write_reg(3'(k), 16'h1111 * 16'(k));
    for (int k = 0; k < 8; k++) begin
      SR1MUX = 1'b1; IR = mk_ir(3'd0, 3'(k), 3'(k)); #1;
      exp_v = 16'h1111 * 16'(k);
      check($sformatf("rw_sr1_r%0d", k), SR1OUT, exp_v);
      check($sformatf("rw_sr2_r%0d", k), SR2OUT, exp_v);
    end

    // DRMUX=1 targets R7 regardless of IR[11:9].
    idle();
    IR = mk_ir(3'd6, 3'd0, 3'd0); BUS = 16'hBEEF; DRMUX = 1'b1; LD_REG = 1'b1;
    step();
    idle();
    SR1MUX = 1'b1; IR = mk_ir(3'd0, 3'd7, 3'd6); #1;
    check("drmux_r7", SR1OUT, 16'hBEEF);
    check("drmux_r6_kept", SR2OUT, 16'h6666);

    // Condition codes.
    load_cc(16'h8000);
    check("cc_neg", {13'b0, N, Z, P}, 16'h0004);
    load_cc(16'h0000);
    check("cc_zero", {13'b0, N, Z, P}, 16'h0002);
    load_cc(16'h7FFF);
    check("cc_pos", {13'b0, N, Z, P}, 16'h0001);
    step();
    check("cc_hold", {13'b0, N, Z, P}, 16'h0001);

    // BEN ordering against a simultaneous CC load.
    load_cc(16'h0000);
    IR = mk_ir(3'b010, 3'd0, 3'd0); BUS = 16'hFFFF; LD_CC = 1'b1; LD_BEN = 1'b1;
    step();
    idle();
    check("ben_old_nzp", {15'b0, BEN}, 16'h0001);
    check("ben_new_nzp", {13'b0, N, Z, P}, 16'h0004);
    LD_BEN = 1'b1;
    step();
    idle();
    check("ben_next", {15'b0, BEN}, 16'h0000);

    // Immediate sign extension and SR2MUX_SEL.
    IR = 16'h0010; #1;
    check("imm_neg", IMME, 16'hFFF0);
    check("sel_0", {15'b0, SR2MUX_SEL}, 16'h0000);
    IR = 16'h002F; #1;
    check("imm_pos", IMME, 16'h000F);
    check("sel_1", {15'b0, SR2MUX_SEL}, 16'h0001);

    // Simultaneous register write and CC load from the same BUS value.
    idle();
    IR = mk_ir(3'd1, 3'd0, 3'd0); BUS = 16'h0042; LD_REG = 1'b1; LD_CC = 1'b1;
    step();
    idle();
    IR = mk_ir(3'd1, 3'd0, 3'd1); #1;
    check("reg_cc_r1", SR2OUT, 16'h0042);
    check("reg_cc_nzp", {13'b0, N, Z, P}, 16'h0001);

    // Write-through visibility before the edge, and the registered value after it.
    write_reg(3'd2, 16'h0005);
    IR = mk_ir(3'd2, 3'd0, 3'd2); BUS = 16'h00AA; LD_REG = 1'b1; #1;
`ifdef REG_BYPASS_EN
    exp_v = 16'h00AA;
`else
    exp_v = 16'h0005;
`endif
    check("bypass_sr1_pre", SR1OUT, exp_v);
    check("bypass_sr2_pre", SR2OUT, exp_v);
    step();
    idle();
    check("bypass_sr1_post", SR1OUT, 16'h00AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
